// File: rtl/div_seq_ctrl.sv
// Multi-cycle DIV/DIVU sequencer: radix-2 restoring shift-subtract loop with sign fix-up.
// Optional macro DIV_BYZERO_FAST_EN: a zero divisor skips the loop and completes in one edge.
module div_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             annul,
  output logic             stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic             sign_q;
  logic             sign_r;

  logic             accept;
  logic             last_iter;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             q_bit;

  assign accept    = (state == IDLE) && start && !annul;
  assign last_iter = (cnt == CW'(WIDTH - 1));
  assign abs_a     = (is_signed && opa[WIDTH-1]) ? -opa : opa;
  assign abs_b     = (is_signed && opb[WIDTH-1]) ? -opb : opb;

  // The dividend register doubles as the quotient register: its MSB feeds the
  // partial remainder while the new quotient bit enters at the LSB.
  assign rem_sh   = {rem, dvd[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, divisor};
  assign q_bit    = (rem_sh >= {1'b0, divisor});

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    stall        = 1'b0;
    result_valid = 1'b0;
    case (state)
      IDLE: begin
        stall = start && !annul;
        if (accept) begin
`ifdef DIV_BYZERO_FAST_EN
          state_nx = (opb == '0) ? DONE : BUSY;
`else
          state_nx = BUSY;
`endif
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (annul) begin
          state_nx = IDLE;
        end else if (last_iter) begin
          state_nx = FIXUP;
        end
      end
      FIXUP: begin
        stall    = 1'b1;
        state_nx = annul ? IDLE : DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // hi/lo are only written when a result commits, so an annulled operation
  // leaves the previous HI/LO visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      divisor <= '0;
      rem     <= '0;
      dvd     <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt     <= '0;
            divisor <= abs_b;
            dvd     <= abs_a;
            rem     <= '0;
            sign_q  <= is_signed && (opa[WIDTH-1] ^ opb[WIDTH-1]);
            sign_r  <= is_signed && opa[WIDTH-1];
`ifdef DIV_BYZERO_FAST_EN
            if (opb == '0) begin
              lo <= '1;
              hi <= opa;
            end
`endif
          end
        end
        BUSY: begin
          if (!annul) begin
            cnt <= cnt + 1'b1;
            rem <= q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], q_bit};
          end
        end
        FIXUP: begin
          if (!annul) begin
            lo <= sign_q ? -dvd : dvd;
            hi <= sign_r ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: directed cases plus random operands against an arithmetic model.
`timescale 1ns/1ps
module tb_div_seq_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         annul;
  logic         stall;
  logic         result_valid;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t expq[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .is_signed    (is_signed),
    .opa          (opa),
    .opb          (opb),
    .annul        (annul),
    .stall        (stall),
    .result_valid (result_valid),
    .hi           (hi),
    .lo           (lo)
  );

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Architectural DIV/DIVU semantics: truncating division, remainder takes the
  // dividend's sign; divide by zero yields an all-ones magnitude quotient.
  function automatic void refDiv(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                                 output logic [W-1:0] eh, output logic [W-1:0] el);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == '0) begin
`ifdef DIV_BYZERO_FAST_EN
      el = '1;
      eh = a;
`else
      el = (sgn && a[W-1]) ? 32'd1 : 32'hFFFF_FFFF;
      eh = a;
`endif
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      el = q[W-1:0];
      eh = r[W-1:0];
    end else begin
      el = a / b;
      eh = a % b;
    end
  endfunction

  function automatic int expStall(input logic [W-1:0] b);
`ifdef DIV_BYZERO_FAST_EN
    if (b == '0) return 1;
`endif
    return W + 2;
  endfunction

  // Monitor: every strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && result_valid === 1'b1) begin
      if (expq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_strobe: result_valid=1 hi=0x%08h lo=0x%08h, expected no strobe", hi, lo);
      end else begin
        e = expq.pop_front();
        checkOutput("result_hi", hi, e.hi);
        checkOutput("result_lo", lo, e.lo);
      end
    end
  end

  // Called just after an edge; counts stall cycles until the strobe cycle.
  task automatic waitResult(input bit hold, output int n, output bit seen);
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      if (stall === 1'b1) n++;
      if (result_valid === 1'b1) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                               input bit hold, output int n, output bit seen);
    exp_t e;
    @(negedge clk);
    start     = 1'b1;
    is_signed = sgn;
    opa       = a;
    opb       = b;
    refDiv(a, b, sgn, e.hi, e.lo);
    expq.push_back(e);
    #1;
    waitResult(hold, n, seen);
  endtask

  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn, input string tag);
    int n;
    bit seen;
    applyStimulus(a, b, sgn, 1'b0, n, seen);
    checkOutput({tag, "_strobe"}, W'(seen), W'(1));
    checkOutput({tag, "_stall_cycles"}, W'(n), W'(expStall(b)));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  n;
    bit  seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bit  rs;
    exp_t e;

    rst = 1'b1; start = 1'b0; annul = 1'b0; is_signed = 1'b0; opa = '0; opb = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_stall", W'(stall), '0);
    checkOutput("reset_valid", W'(result_valid), '0);
    checkOutput("reset_hi", hi, '0);
    checkOutput("reset_lo", lo, '0);
    rst = 1'b0;

    runOp(32'd100, 32'd7, 1'b0, "divu_100_7");
    $display("[TB] directed DIVU 100/7 issued");

    // Annul at cnt==10: no strobe, HI/LO keep 2/14.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; opa = 32'd50; opb = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1; annul = 1'b1;
    @(posedge clk); #1; annul = 1'b0;
    checkOutput("annul_stall", W'(stall), '0);
    checkOutput("annul_valid", W'(result_valid), '0);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("annul_hold_hi", hi, 32'd2);
    checkOutput("annul_hold_lo", lo, 32'd14);

    runOp(32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2");
    runOp(32'd7, 32'hFFFF_FFFE, 1'b1, "div_7_m2");
    runOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_overflow");
    runOp(32'd5, 32'd0, 1'b0, "divu_by_zero");
    runOp(32'hFFFF_FFF0, 32'd0, 1'b1, "div_neg_by_zero");

    // start held high through DONE: one strobe, then a fresh op from IDLE.
    applyStimulus(32'd1000, 32'd9, 1'b0, 1'b1, n, seen);
    checkOutput("hold_first_strobe", W'(seen), W'(1));
    @(posedge clk); #1;
    refDiv(32'd1000, 32'd9, 1'b0, e.hi, e.lo);
    expq.push_back(e);
    waitResult(1'b0, n, seen);
    checkOutput("hold_second_strobe", W'(seen), W'(1));
    checkOutput("hold_second_stall", W'(n), W'(W + 2));
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      rb = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      rs = 1'($urandom_range(0, 1));
      runOp(ra, rb, rs, "random");
    end

    // Reset mid-BUSY aborts with everything cleared.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; opa = 32'd12345; opb = 32'd11;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    checkOutput("midrst_stall", W'(stall), '0);
    checkOutput("midrst_valid", W'(result_valid), '0);
    checkOutput("midrst_hi", hi, '0);
    checkOutput("midrst_lo", lo, '0);
    repeat (40) @(posedge clk);
    #1;

    checkOutput("pending_results", W'(expq.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
